// File: rtl/edac_access_ctrl_if.sv
// edac_access_ctrl_if: CPU-side request/ack bus of the EDAC access sequencer.
// The master drives the request; the slave answers with ACK/RDATA/ERR.
interface edac_access_ctrl_if #(
  parameter int AW = 10
) ();
  logic          REQ;
  logic          WE;
  logic [AW-1:0] ADDR;
  logic [31:0]   WDATA;
  logic          ACK;
  logic [31:0]   RDATA;
  logic          ERR;

  modport master (
    output REQ, WE, ADDR, WDATA,
    input  ACK, RDATA, ERR
  );

  modport slave (
    input  REQ, WE, ADDR, WDATA,
    output ACK, RDATA, ERR
  );
endinterface

// File: rtl/edac_access_ctrl.sv
// edac_access_ctrl: sequences CPU loads/stores through a shared EDAC block.
// Background scrubber is built only when EDAC_SCRUB_EN is defined.
module edac_access_ctrl #(
  parameter int          AW           = 10,
  parameter logic [31:0] ERR_CODE     = 32'hFFFF_FFFF,
  parameter int          SCRUB_PERIOD = 256
) (
  input  logic              CLK,
  input  logic              RST_N,
  edac_access_ctrl_if.slave cpu,
  output logic              BUSY,
  output logic [7:0]        ERR_CNT,
  output logic              EDAC_EN,
  output logic              EDAC_READ,
  output logic [31:0]       EDAC_DIN,
  input  logic [31:0]       EDAC_DOUT,
  output logic [AW-1:0]     MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ENC,
    S_WR_MEM,
    S_RD_MEM,
    S_RD_DEC,
    S_RD_CAP,
    S_DONE
`ifdef EDAC_SCRUB_EN
    ,
    S_SC_RD,
    S_SC_DEC,
    S_SC_ENC,
    S_SC_WR
`endif
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [7:0]    r_err_cnt;

  logic          w_dout_bad;
  logic          w_cnt_sat;

  assign w_dout_bad = (EDAC_DOUT == ERR_CODE);
  assign w_cnt_sat  = &r_err_cnt;

`ifdef EDAC_SCRUB_EN
  localparam int TW = $clog2(SCRUB_PERIOD);

  logic [TW-1:0] r_timer;
  logic [AW-1:0] r_sc_addr;
  logic          w_scrub_due;

  assign w_scrub_due = (r_timer == TW'(SCRUB_PERIOD - 1));
`else
  logic w_unused_sp;

  assign w_unused_sp = |SCRUB_PERIOD;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
`ifdef EDAC_SCRUB_EN
      r_timer   <= '0;
      r_sc_addr <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu.REQ) begin
            r_addr  <= cpu.ADDR;
            r_wdata <= cpu.WDATA;
            r_err   <= 1'b0;
            r_state <= cpu.WE ? S_WR_ENC : S_RD_MEM;
`ifdef EDAC_SCRUB_EN
            r_timer <= '0;
          end else if (w_scrub_due) begin
            r_timer <= '0;
            r_state <= S_SC_RD;
          end else begin
            r_timer <= r_timer + 1'b1;
`endif
          end
        end
        S_WR_ENC: r_state <= S_WR_MEM;
        S_WR_MEM: r_state <= S_DONE;
        S_RD_MEM: r_state <= S_RD_DEC;
        S_RD_DEC: r_state <= S_RD_CAP;
        S_RD_CAP: begin
          r_rdata <= EDAC_DOUT;
          r_err   <= w_dout_bad;
          if (w_dout_bad && !w_cnt_sat)
            r_err_cnt <= r_err_cnt + 8'd1;
          r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
`ifdef EDAC_SCRUB_EN
        S_SC_RD:  r_state <= S_SC_DEC;
        S_SC_DEC: r_state <= S_SC_ENC;
        // An uncorrectable word is left as-is rather than re-encoded.
        S_SC_ENC: begin
          if (w_dout_bad) begin
            if (!w_cnt_sat)
              r_err_cnt <= r_err_cnt + 8'd1;
            r_sc_addr <= r_sc_addr + 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_SC_WR;
          end
        end
        S_SC_WR: begin
          r_sc_addr <= r_sc_addr + 1'b1;
          r_state   <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes follow the state register, so reset drops them immediately.
  always_comb begin
    EDAC_EN   = 1'b0;
    EDAC_READ = 1'b0;
    EDAC_DIN  = '0;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    MEM_ADDR  = r_addr;
    case (r_state)
      S_WR_ENC: begin
        EDAC_EN  = 1'b1;
        EDAC_DIN = r_wdata;
      end
      S_WR_MEM: begin
        MEM_WE    = 1'b1;
        MEM_WDATA = EDAC_DOUT;
      end
      S_RD_MEM: MEM_RE = 1'b1;
      S_RD_DEC: begin
        EDAC_EN   = 1'b1;
        EDAC_READ = 1'b1;
        EDAC_DIN  = MEM_RDATA;
      end
`ifdef EDAC_SCRUB_EN
      S_SC_RD: begin
        MEM_RE   = 1'b1;
        MEM_ADDR = r_sc_addr;
      end
      S_SC_DEC: begin
        EDAC_EN   = 1'b1;
        EDAC_READ = 1'b1;
        EDAC_DIN  = MEM_RDATA;
        MEM_ADDR  = r_sc_addr;
      end
      S_SC_ENC: begin
        EDAC_EN  = 1'b1;
        EDAC_DIN = EDAC_DOUT;
        MEM_ADDR = r_sc_addr;
      end
      S_SC_WR: begin
        MEM_WE    = 1'b1;
        MEM_WDATA = EDAC_DOUT;
        MEM_ADDR  = r_sc_addr;
      end
`endif
      default: ;
    endcase
  end

  assign cpu.ACK   = (r_state == S_DONE);
  assign cpu.ERR   = (r_state == S_DONE) && r_err;
  assign cpu.RDATA = r_rdata;
  assign BUSY      = (r_state != S_IDLE);
  assign ERR_CNT   = r_err_cnt;

endmodule
